// File: rtl/lap_recorder.sv
// rtl/lap_recorder.sv - lap capture with mixed-radix lap duration and FIFO of split/lap pairs
// Head outputs are computed from next-state pointers so they track the FIFO head with count.
module lap_recorder #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        ms_in,
  input  logic [5:0]        sec_in,
  input  logic [5:0]        min_in,
  input  logic              lap_btn,
  input  logic              next_btn,
  input  logic              clear,
  output logic [9:0]        split_ms_out,
  output logic [5:0]        split_sec_out,
  output logic [5:0]        split_min_out,
  output logic [9:0]        lap_ms_out,
  output logic [5:0]        lap_sec_out,
  output logic [5:0]        lap_min_out,
  output logic              head_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic              lap_prev_q, lap_prev_d, next_prev_q, next_prev_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [21:0]       last_split_q, last_split_d;
  logic [43:0]       head_q, head_d;
  logic              head_valid_q, head_valid_d;
  logic [43:0]       mem_q [DEPTH];

  logic              push, pop, do_push, do_pop, mem_we;
  logic [10:0]       ms_diff;
  logic [6:0]        sec_diff, min_diff;
  logic [9:0]        lap_ms;
  logic [5:0]        lap_sec, lap_min;
  logic              borrow_s, borrow_m;
  logic [21:0]       sample;
  logic [43:0]       wr_data;

  always_comb begin
    push = lap_btn & ~lap_prev_q;
    pop  = next_btn & ~next_prev_q;
    lap_prev_d  = lap_btn;
    next_prev_d = next_btn;

    // Borrow chain: ms borrows from sec, sec borrows from min, min wraps mod 60.
    ms_diff  = {1'b0, ms_in} - {1'b0, last_split_q[9:0]};
    borrow_s = ms_diff[10];
    lap_ms   = borrow_s ? 10'(ms_diff + 11'd1000) : ms_diff[9:0];
    sec_diff = {1'b0, sec_in} - {1'b0, last_split_q[15:10]} - {6'd0, borrow_s};
    borrow_m = sec_diff[6];
    lap_sec  = borrow_m ? 6'(sec_diff + 7'd60) : sec_diff[5:0];
    min_diff = {1'b0, min_in} - {1'b0, last_split_q[21:16]} - {6'd0, borrow_m};
    lap_min  = min_diff[6] ? 6'(min_diff + 7'd60) : min_diff[5:0];

    sample  = {min_in, sec_in, ms_in};
    wr_data = {sample, lap_min, lap_sec, lap_ms};

    do_pop  = pop & (count_q != '0);
    do_push = push & ((count_q != DEPTH_C) | do_pop);
    mem_we  = do_push & ~clear;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    last_split_d = last_split_q;

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      last_split_d = '0;
    end else begin
      if (push) last_split_d = sample;
      if (push && !do_push) overflow_d = 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    head_valid_d = (count_d != '0);
    if (count_d == '0) head_d = '0;
    else if (mem_we && wr_ptr_q == rd_ptr_d) head_d = wr_data;
    else head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_prev_q   <= 1'b1;
      next_prev_q  <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      last_split_q <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      lap_prev_q   <= lap_prev_d;
      next_prev_q  <= next_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      last_split_q <= last_split_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

  assign {split_min_out, split_sec_out, split_ms_out} = head_q[43:22];
  assign {lap_min_out, lap_sec_out, lap_ms_out}       = head_q[21:0];
  assign head_valid = head_valid_q;
  assign count      = count_q;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_lap_recorder.sv
// tb/tb_lap_recorder.sv - directed self-checking bench for lap_recorder
module tb_lap_recorder;

  logic       clk = 1'b0;
  logic       reset, lap_btn, next_btn, clear;
  logic [9:0] ms_in;
  logic [5:0] sec_in, min_in;
  logic [9:0] split_ms_out, lap_ms_out;
  logic [5:0] split_sec_out, split_min_out, lap_sec_out, lap_min_out;
  logic       head_valid, full, empty, overflow;
  logic [3:0] count;
  int         vectors = 0;
  int         miscompares = 0;

  logic [21:0] split_w, lap_w;
  assign split_w = {split_min_out, split_sec_out, split_ms_out};
  assign lap_w   = {lap_min_out, lap_sec_out, lap_ms_out};

  lap_recorder #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .ms_in(ms_in), .sec_in(sec_in), .min_in(min_in),
    .lap_btn(lap_btn), .next_btn(next_btn), .clear(clear),
    .split_ms_out(split_ms_out), .split_sec_out(split_sec_out), .split_min_out(split_min_out),
    .lap_ms_out(lap_ms_out), .lap_sec_out(lap_sec_out), .lap_min_out(lap_min_out),
    .head_valid(head_valid), .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int m, input int s, input int ms);
    min_in = 6'(m); sec_in = 6'(s); ms_in = 10'(ms);
  endtask

  task automatic press(input int m, input int s, input int ms);
    set_time(m, s, ms);
    lap_btn = 1'b1; step();
    lap_btn = 1'b0; step();
  endtask

  task automatic pop_one();
    next_btn = 1'b1; step();
    next_btn = 1'b0; step();
  endtask

  task automatic do_clear();
    clear = 1'b1; step();
    clear = 1'b0; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; lap_btn = 1'b1; next_btn = 1'b0; clear = 1'b0; set_time(0, 7, 123);
    repeat (3) step();
    reset = 1'b0;
    repeat (5) step();
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL reset_flags empty=%b full=%b want 1 0", empty, full); end
    vectors++; if (head_valid !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL reset_hv_ovf hv=%b ovf=%b want 0 0", head_valid, overflow); end
    vectors++; if (split_w !== 22'd0 || lap_w !== 22'd0) begin miscompares++; $display("FAIL reset_head split=%h lap=%h want 0 0", split_w, lap_w); end
    lap_btn = 1'b0; step();
  endtask

  task automatic test_basic();
    press(0, 1, 250);
    vectors++; if (count !== 4'd1 || head_valid !== 1'b1) begin miscompares++; $display("FAIL basic_count1 count=%0d hv=%b want 1 1", count, head_valid); end
    vectors++; if (split_w !== {6'd0, 6'd1, 10'd250} || lap_w !== {6'd0, 6'd1, 10'd250}) begin miscompares++; $display("FAIL basic_first split=%h lap=%h want %h %h", split_w, lap_w, {6'd0, 6'd1, 10'd250}, {6'd0, 6'd1, 10'd250}); end
    press(0, 3, 100);
    vectors++; if (count !== 4'd2 || split_w !== {6'd0, 6'd1, 10'd250}) begin miscompares++; $display("FAIL basic_count2 count=%0d split=%h want 2 %h", count, split_w, {6'd0, 6'd1, 10'd250}); end
    next_btn = 1'b1; step();
    vectors++; if (split_w !== {6'd0, 6'd3, 10'd100} || lap_w !== {6'd0, 6'd1, 10'd850}) begin miscompares++; $display("FAIL basic_pop_head split=%h lap=%h want %h %h", split_w, lap_w, {6'd0, 6'd3, 10'd100}, {6'd0, 6'd1, 10'd850}); end
    vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL basic_pop_count got %0d want 1", count); end
    next_btn = 1'b0; step();
    pop_one();
    vectors++; if (empty !== 1'b1 || head_valid !== 1'b0 || split_w !== 22'd0) begin miscompares++; $display("FAIL basic_drain empty=%b hv=%b split=%h want 1 0 0", empty, head_valid, split_w); end
    pop_one();
    vectors++; if (count !== 4'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL basic_pop_empty count=%0d empty=%b want 0 1", count, empty); end
  endtask

  task automatic test_wrap();
    do_clear();
    press(59, 59, 900);
    vectors++; if (lap_w !== {6'd59, 6'd59, 10'd900}) begin miscompares++; $display("FAIL wrap_first lap=%h want %h", lap_w, {6'd59, 6'd59, 10'd900}); end
    press(0, 0, 150);
    pop_one();
    vectors++; if (split_w !== {6'd0, 6'd0, 10'd150} || lap_w !== {6'd0, 6'd0, 10'd250}) begin miscompares++; $display("FAIL wrap_lap split=%h lap=%h want %h %h", split_w, lap_w, {6'd0, 6'd0, 10'd150}, {6'd0, 6'd0, 10'd250}); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int k = 1; k <= 8; k++) press(0, k, 0);
    vectors++; if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_full full=%b count=%0d ovf=%b want 1 8 0", full, count, overflow); end
    vectors++; if (split_w !== {6'd0, 6'd1, 10'd0} || lap_w !== {6'd0, 6'd1, 10'd0}) begin miscompares++; $display("FAIL ovf_head split=%h lap=%h want %h %h", split_w, lap_w, {6'd0, 6'd1, 10'd0}, {6'd0, 6'd1, 10'd0}); end
    press(0, 9, 0);
    vectors++; if (overflow !== 1'b1 || count !== 4'd8) begin miscompares++; $display("FAIL ovf_drop ovf=%b count=%0d want 1 8", overflow, count); end
    pop_one();
    vectors++; if (count !== 4'd7 || lap_w !== {6'd0, 6'd1, 10'd0}) begin miscompares++; $display("FAIL ovf_pop count=%0d lap=%h want 7 %h", count, lap_w, {6'd0, 6'd1, 10'd0}); end
    press(0, 12, 0);
    for (int k = 0; k < 7; k++) pop_one();
    vectors++; if (count !== 4'd1 || split_w !== {6'd0, 6'd12, 10'd0} || lap_w !== {6'd0, 6'd3, 10'd0}) begin miscompares++; $display("FAIL ovf_ref count=%0d split=%h lap=%h want 1 %h %h", count, split_w, lap_w, {6'd0, 6'd12, 10'd0}, {6'd0, 6'd3, 10'd0}); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int k = 1; k <= 8; k++) press(0, k, 0);
    set_time(0, 20, 0);
    lap_btn = 1'b1; next_btn = 1'b1; step();
    vectors++; if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin miscompares++; $display("FAIL b2b_full count=%0d ovf=%b full=%b want 8 0 1", count, overflow, full); end
    vectors++; if (split_w !== {6'd0, 6'd2, 10'd0}) begin miscompares++; $display("FAIL b2b_full_head split=%h want %h", split_w, {6'd0, 6'd2, 10'd0}); end
    lap_btn = 1'b0; next_btn = 1'b0; step();
    do_clear();
    set_time(0, 5, 0);
    lap_btn = 1'b1; next_btn = 1'b1; step();
    vectors++; if (count !== 4'd1 || head_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_empty count=%0d hv=%b want 1 1", count, head_valid); end
    vectors++; if (split_w !== {6'd0, 6'd5, 10'd0} || lap_w !== {6'd0, 6'd5, 10'd0}) begin miscompares++; $display("FAIL b2b_empty_head split=%h lap=%h want %h %h", split_w, lap_w, {6'd0, 6'd5, 10'd0}, {6'd0, 6'd5, 10'd0}); end
    lap_btn = 1'b0; next_btn = 1'b0; step();
  endtask

  task automatic test_clear();
    do_clear();
    for (int k = 1; k <= 9; k++) press(1, k, 0);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL clr_pre ovf=%b want 1", overflow); end
    set_time(3, 30, 0);
    clear = 1'b1; lap_btn = 1'b1; step();
    vectors++; if (count !== 4'd0 || overflow !== 1'b0 || empty !== 1'b1 || head_valid !== 1'b0) begin miscompares++; $display("FAIL clr_push count=%0d ovf=%b empty=%b hv=%b want 0 0 1 0", count, overflow, empty, head_valid); end
    clear = 1'b0; lap_btn = 1'b0; step();
    press(0, 2, 0);
    vectors++; if (split_w !== {6'd0, 6'd2, 10'd0} || lap_w !== {6'd0, 6'd2, 10'd0}) begin miscompares++; $display("FAIL clr_lap split=%h lap=%h want %h %h", split_w, lap_w, {6'd0, 6'd2, 10'd0}, {6'd0, 6'd2, 10'd0}); end
    press(0, 4, 500);
    reset = 1'b1; step();
    reset = 1'b0; step();
    vectors++; if (count !== 4'd0 || head_valid !== 1'b0 || split_w !== 22'd0) begin miscompares++; $display("FAIL midreset count=%0d hv=%b split=%h want 0 0 0", count, head_valid, split_w); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lap_recorder.md
Name: lap_recorder

Overview:
- Downstream consumer of the stopwatch time outputs (ms 0-999, sec 0-59, min 0-59).
- Captures a split time on each rising edge of a lap button.
- Computes the lap duration: the current split minus the previous split, in mixed radix.
- Stores split/lap pairs in a FIFO of DEPTH entries, read back one entry at a time by a "next" button for display.

Parameters:
- DEPTH, 8, number of stored laps; power of 2, 2..64.
- ADDR_W, 3, log2(DEPTH).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ms_in  input  10  stopwatch milliseconds, 0-999.
- sec_in  input  6  stopwatch seconds, 0-59.
- min_in  input  6  stopwatch minutes, 0-59.
- lap_btn  input  1  level; already synchronized/debounced; rising edge = capture.
- next_btn  input  1  level; already synchronized/debounced; rising edge = pop head entry.
- clear  input  1  synchronous clear of buffer and lap reference.
- split_ms_out / split_sec_out / split_min_out  output  10/6/6  head entry split time.
- lap_ms_out / lap_sec_out / lap_min_out  output  10/6/6  head entry lap duration.
- head_valid  output  1  head outputs hold a stored entry.
- count  output  ADDR_W+1  entries stored, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a capture was dropped.

Behaviour:
- Edge detect:
  - lap_prev and next_prev registers; push = lap_btn & ~lap_prev; pop = next_btn & ~next_prev.
  - Both prev registers reset to 1, so a button held through reset does not fire.
  - clear does not touch the prev registers.
- Capture (push):
  - Samples ms_in/sec_in/min_in in the edge cycle.
  - Lap = sample - last_split, computed in mixed radix:
    - ms: borrow at 1000.
    - sec: borrow at 60.
    - min: subtract modulo 60 (wraps past 59:59.999).
  - Arithmetic: ms diff as 11-bit signed; if negative, add 1000 and set the sec borrow. Same scheme for sec with 60. min = (min_in - last_min - borrow) mod 60.
  - Writes {split, lap} at wr_ptr; last_split <= sample.
  - count/full/empty update the next cycle.
- last_split resets and clears to 00:00.000, so the first lap equals its split.
- Push when full (and no pop in the same cycle):
  - Entry dropped; overflow <= 1.
  - last_split is still updated, so the next lap stays relative to the real previous press.
- Pop when empty: ignored; no state change.
- Simultaneous push and pop:
  - Both are performed; count is unchanged.
  - When full, the push is accepted and overflow is not set.
  - When empty, only the push takes effect; count becomes 1.
- Head outputs:
  - Registered from mem[rd_ptr]; they reflect the new head one cycle after any push or pop that changes it.
  - head_valid = !empty, registered and aligned with the head outputs.
  - When empty, all split/lap outputs read 0.
- Pointers: wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH.
- clear:
  - Pointers, count, overflow, last_split and head outputs go to 0 next cycle.
  - Takes priority over push/pop in the same cycle; those events are discarded.
- reset:
  - Clears the same state as clear; prev registers go to 1.
  - Memory contents are don't-care.
  - Outputs after reset: all time outputs 0, head_valid 0, count 0, empty 1, full 0, overflow 0.
  - Reset mid-operation discards all stored laps.
- Out-of-range inputs (ms > 999 etc.) are not checked; results are undefined.

Test Plan:
1. Reset with lap_btn held high, then keep it high 5 cycles -> no capture; count 0, empty 1.
2. Push at 00:01.250, then at 00:03.100 -> entries:
   - split 00:01.250, lap 00:01.250;
   - split 00:03.100, lap 00:01.850.
   - Pop -> head becomes the second entry one cycle later.
3. Push at 59:59.900, then at 00:00.150 -> lap 00:00.250 (minute wraps, ms/sec borrow chain).
4. Push 9 times with DEPTH=8:
   - full 1 after the 8th push;
   - 9th push dropped, overflow 1, count 8;
   - the 9th press's split is still used as the reference for the next lap.
5. Same-cycle push and pop:
   - when full -> count stays 8, overflow stays 0;
   - when empty -> count becomes 1, head_valid 1.
6. clear asserted in the same cycle as push -> count 0, overflow 0; next push at 00:02.000 gives lap 00:02.000.
